// File: rtl/axi_lite_xbar_pkg.sv
// axi_lite_xbar_pkg: response type/constants and FSM states for the AXI-lite crossbar.
// XBAR_DECERR_EN adds the R_ERR/W_ERR states used to answer unmapped addresses.
package axi_lite_xbar_pkg;
  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_DECERR = 2'b11;
`ifdef XBAR_DECERR_EN
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ERR} w_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
`endif
endpackage

// File: rtl/xbar_addr_dec.sv
// xbar_addr_dec: address decode to slave select (slave 1 wins) plus unmapped flag.
module xbar_addr_dec #(
  parameter logic [31:0] SLV1_BASE = 32'hA000_0000,
  parameter logic [31:0] SLV1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV0_MASK = 32'hF800_0000
) (
  input  logic [31:0] addr,
  output logic        sel,
  output logic        err
);
  logic hit1, hit0;
  assign hit1 = (addr & SLV1_MASK) == SLV1_BASE;
  assign hit0 = (addr & SLV0_MASK) == SLV0_BASE;
  assign sel  = hit1;
  assign err  = !hit1 && !hit0;
endmodule

// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: one-master to two-slave AXI-lite router, one outstanding read and write.
// XBAR_DECERR_EN: unmapped addresses answer DECERR; otherwise they route to slave 0.
module axi_lite_xbar
  import axi_lite_xbar_pkg::*;
#(
  parameter logic [31:0] SLV1_BASE = 32'hA000_0000,
  parameter logic [31:0] SLV1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV0_MASK = 32'hF800_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slv_ar_valid_i,
  input  logic [31:0] slv_ar_addr_i,
  output logic        slv_ar_ready_o,
  output logic        slv_r_valid_o,
  output logic [31:0] slv_r_data_o,
  output axi_resp_t   slv_r_resp_o,
  input  logic        slv_r_ready_i,
  input  logic        slv_aw_valid_i,
  input  logic [31:0] slv_aw_addr_i,
  output logic        slv_aw_ready_o,
  input  logic        slv_w_valid_i,
  input  logic [31:0] slv_w_data_i,
  input  logic [3:0]  slv_w_strb_i,
  output logic        slv_w_ready_o,
  output logic        slv_b_valid_o,
  output axi_resp_t   slv_b_resp_o,
  input  logic        slv_b_ready_i,
  output logic        s0_ar_valid_o,
  output logic [31:0] s0_ar_addr_o,
  input  logic        s0_ar_ready_i,
  input  logic        s0_r_valid_i,
  input  logic [31:0] s0_r_data_i,
  input  axi_resp_t   s0_r_resp_i,
  output logic        s0_r_ready_o,
  output logic        s0_aw_valid_o,
  output logic [31:0] s0_aw_addr_o,
  input  logic        s0_aw_ready_i,
  output logic        s0_w_valid_o,
  output logic [31:0] s0_w_data_o,
  output logic [3:0]  s0_w_strb_o,
  input  logic        s0_w_ready_i,
  input  logic        s0_b_valid_i,
  input  axi_resp_t   s0_b_resp_i,
  output logic        s0_b_ready_o,
  output logic        s1_ar_valid_o,
  output logic [31:0] s1_ar_addr_o,
  input  logic        s1_ar_ready_i,
  input  logic        s1_r_valid_i,
  input  logic [31:0] s1_r_data_i,
  input  axi_resp_t   s1_r_resp_i,
  output logic        s1_r_ready_o,
  output logic        s1_aw_valid_o,
  output logic [31:0] s1_aw_addr_o,
  input  logic        s1_aw_ready_i,
  output logic        s1_w_valid_o,
  output logic [31:0] s1_w_data_o,
  output logic [3:0]  s1_w_strb_o,
  input  logic        s1_w_ready_i,
  input  logic        s1_b_valid_i,
  input  axi_resp_t   s1_b_resp_i,
  output logic        s1_b_ready_o
);
  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic [31:0] r_addr, aw_addr_q, w_data_q, w_dec_addr;
  logic [3:0]  w_strb_q;
  logic        r_sel, w_sel, r_dec_sel, w_dec_sel, r_unmapped, w_unmapped;
  logic        aw_cap, w_cap, aw_cap_d, w_cap_d;
  logic        ar_hs, aw_hs, w_hs, w_both, r_pass, b_pass, r_err_st, w_err_st;
  logic        ar_v, aw_v, w_v, aw_rdy, w_rdy;

  xbar_addr_dec #(.SLV1_BASE(SLV1_BASE), .SLV1_MASK(SLV1_MASK), .SLV0_BASE(SLV0_BASE), .SLV0_MASK(SLV0_MASK))
    u_rdec (.addr(slv_ar_addr_i), .sel(r_dec_sel), .err(r_unmapped));
  xbar_addr_dec #(.SLV1_BASE(SLV1_BASE), .SLV1_MASK(SLV1_MASK), .SLV0_BASE(SLV0_BASE), .SLV0_MASK(SLV0_MASK))
    u_wdec (.addr(w_dec_addr), .sel(w_dec_sel), .err(w_unmapped));

`ifdef XBAR_DECERR_EN
  assign r_err_st = r_state == R_ERR;
  assign w_err_st = w_state == W_ERR;
`else
  logic unused_unmapped;
  assign unused_unmapped = r_unmapped ^ w_unmapped;
  assign r_err_st = 1'b0;
  assign w_err_st = 1'b0;
`endif

  // read path
  assign slv_ar_ready_o = r_state == R_IDLE;
  assign ar_hs  = slv_ar_valid_i && slv_ar_ready_o;
  assign ar_v   = r_state == R_ADDR;
  assign r_pass = r_state == R_DATA;
  assign s0_ar_valid_o = ar_v && !r_sel;
  assign s1_ar_valid_o = ar_v && r_sel;
  assign s0_ar_addr_o  = s0_ar_valid_o ? r_addr : '0;
  assign s1_ar_addr_o  = s1_ar_valid_o ? r_addr : '0;
  assign s0_r_ready_o  = r_pass && !r_sel && slv_r_ready_i;
  assign s1_r_ready_o  = r_pass && r_sel && slv_r_ready_i;
  assign slv_r_valid_o = r_pass ? (r_sel ? s1_r_valid_i : s0_r_valid_i) : r_err_st;
  assign slv_r_data_o  = r_pass ? (r_sel ? s1_r_data_i : s0_r_data_i) : '0;
  assign slv_r_resp_o  = r_pass ? (r_sel ? s1_r_resp_i : s0_r_resp_i) : r_err_st ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    r_next = r_state;
    if (r_state == R_IDLE) begin
`ifdef XBAR_DECERR_EN
      if (slv_ar_valid_i) r_next = r_unmapped ? R_ERR : R_ADDR;
`else
      if (slv_ar_valid_i) r_next = R_ADDR;
`endif
    end else if (r_state == R_ADDR) begin
      if (r_sel ? s1_ar_ready_i : s0_ar_ready_i) r_next = R_DATA;
    end else if (slv_r_valid_o && slv_r_ready_i) r_next = R_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) r_addr <= slv_ar_addr_i;
      if (ar_hs) r_sel <= r_dec_sel;
    end

  // write path: in W_IDLE the captured flags mean "latched", in W_REQ they mean "still owed downstream"
  assign slv_aw_ready_o = w_state == W_IDLE && !aw_cap;
  assign slv_w_ready_o  = w_state == W_IDLE && !w_cap;
  assign aw_hs  = slv_aw_valid_i && slv_aw_ready_o;
  assign w_hs   = slv_w_valid_i && slv_w_ready_o;
  assign w_both = (aw_cap || aw_hs) && (w_cap || w_hs);
  assign w_dec_addr = aw_cap ? aw_addr_q : slv_aw_addr_i;
  assign aw_v   = w_state == W_REQ && aw_cap;
  assign w_v    = w_state == W_REQ && w_cap;
  assign b_pass = w_state == W_RESP;
  assign aw_rdy = w_sel ? s1_aw_ready_i : s0_aw_ready_i;
  assign w_rdy  = w_sel ? s1_w_ready_i : s0_w_ready_i;
  assign s0_aw_valid_o = aw_v && !w_sel;
  assign s1_aw_valid_o = aw_v && w_sel;
  assign s0_aw_addr_o  = s0_aw_valid_o ? aw_addr_q : '0;
  assign s1_aw_addr_o  = s1_aw_valid_o ? aw_addr_q : '0;
  assign s0_w_valid_o  = w_v && !w_sel;
  assign s1_w_valid_o  = w_v && w_sel;
  assign s0_w_data_o   = s0_w_valid_o ? w_data_q : '0;
  assign s1_w_data_o   = s1_w_valid_o ? w_data_q : '0;
  assign s0_w_strb_o   = s0_w_valid_o ? w_strb_q : '0;
  assign s1_w_strb_o   = s1_w_valid_o ? w_strb_q : '0;
  assign s0_b_ready_o  = b_pass && !w_sel && slv_b_ready_i;
  assign s1_b_ready_o  = b_pass && w_sel && slv_b_ready_i;
  assign slv_b_valid_o = b_pass ? (w_sel ? s1_b_valid_i : s0_b_valid_i) : w_err_st;
  assign slv_b_resp_o  = b_pass ? (w_sel ? s1_b_resp_i : s0_b_resp_i) : w_err_st ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    w_next   = w_state;
    aw_cap_d = 1'b0;
    w_cap_d  = 1'b0;
    if (w_state == W_IDLE) begin
      aw_cap_d = aw_cap || aw_hs;
      w_cap_d  = w_cap || w_hs;
`ifdef XBAR_DECERR_EN
      if (w_both) w_next = w_unmapped ? W_ERR : W_REQ;
      if (w_both && w_unmapped) aw_cap_d = 1'b0;
      if (w_both && w_unmapped) w_cap_d = 1'b0;
`else
      if (w_both) w_next = W_REQ;
`endif
    end else if (w_state == W_REQ) begin
      aw_cap_d = aw_cap && !aw_rdy;
      w_cap_d  = w_cap && !w_rdy;
      if (!aw_cap_d && !w_cap_d) w_next = W_RESP;
    end else if (slv_b_valid_o && slv_b_ready_i) w_next = W_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      w_state   <= W_IDLE;
      aw_cap    <= 1'b0;
      w_cap     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_sel     <= 1'b0;
    end else begin
      w_state <= w_next;
      aw_cap  <= aw_cap_d;
      w_cap   <= w_cap_d;
      if (aw_hs) aw_addr_q <= slv_aw_addr_i;
      if (w_hs) w_data_q <= slv_w_data_i;
      if (w_hs) w_strb_q <= slv_w_strb_i;
      if (w_state == W_IDLE && w_both) w_sel <= w_dec_sel;
    end
endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb_axi_lite_xbar: directed checks of routing, decode errors, backpressure and reset.
module tb_axi_lite_xbar;
  import axi_lite_xbar_pkg::*;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        slv_ar_valid_i = 0, slv_ar_ready_o, slv_r_valid_o, slv_r_ready_i = 0;
  logic [31:0] slv_ar_addr_i = 0, slv_r_data_o;
  axi_resp_t   slv_r_resp_o, slv_b_resp_o;
  logic        slv_aw_valid_i = 0, slv_aw_ready_o, slv_w_valid_i = 0, slv_w_ready_o;
  logic [31:0] slv_aw_addr_i = 0, slv_w_data_i = 0;
  logic [3:0]  slv_w_strb_i = 0;
  logic        slv_b_valid_o, slv_b_ready_i = 0;
  logic        s0_ar_valid_o, s0_ar_ready_i = 0, s0_r_valid_i = 0, s0_r_ready_o;
  logic        s1_ar_valid_o, s1_ar_ready_i = 0, s1_r_valid_i = 0, s1_r_ready_o;
  logic [31:0] s0_ar_addr_o, s1_ar_addr_o, s0_r_data_i = 0, s1_r_data_i = 0;
  axi_resp_t   s0_r_resp_i = 0, s1_r_resp_i = 0, s0_b_resp_i = 0, s1_b_resp_i = 0;
  logic        s0_aw_valid_o, s0_aw_ready_i = 0, s0_w_valid_o, s0_w_ready_i = 0;
  logic        s1_aw_valid_o, s1_aw_ready_i = 0, s1_w_valid_o, s1_w_ready_i = 0;
  logic [31:0] s0_aw_addr_o, s1_aw_addr_o, s0_w_data_o, s1_w_data_o;
  logic [3:0]  s0_w_strb_o, s1_w_strb_o;
  logic        s0_b_valid_i = 0, s0_b_ready_o, s1_b_valid_i = 0, s1_b_ready_o;
  int          n_tests = 0, n_fail = 0;

  axi_lite_xbar dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o), .slv_r_ready_i(slv_r_ready_i),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i), .slv_w_ready_o(slv_w_ready_o),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_resp_o(slv_b_resp_o), .slv_b_ready_i(slv_b_ready_i),
    .s0_ar_valid_o(s0_ar_valid_o), .s0_ar_addr_o(s0_ar_addr_o), .s0_ar_ready_i(s0_ar_ready_i),
    .s0_r_valid_i(s0_r_valid_i), .s0_r_data_i(s0_r_data_i), .s0_r_resp_i(s0_r_resp_i), .s0_r_ready_o(s0_r_ready_o),
    .s0_aw_valid_o(s0_aw_valid_o), .s0_aw_addr_o(s0_aw_addr_o), .s0_aw_ready_i(s0_aw_ready_i),
    .s0_w_valid_o(s0_w_valid_o), .s0_w_data_o(s0_w_data_o), .s0_w_strb_o(s0_w_strb_o), .s0_w_ready_i(s0_w_ready_i),
    .s0_b_valid_i(s0_b_valid_i), .s0_b_resp_i(s0_b_resp_i), .s0_b_ready_o(s0_b_ready_o),
    .s1_ar_valid_o(s1_ar_valid_o), .s1_ar_addr_o(s1_ar_addr_o), .s1_ar_ready_i(s1_ar_ready_i),
    .s1_r_valid_i(s1_r_valid_i), .s1_r_data_i(s1_r_data_i), .s1_r_resp_i(s1_r_resp_i), .s1_r_ready_o(s1_r_ready_o),
    .s1_aw_valid_o(s1_aw_valid_o), .s1_aw_addr_o(s1_aw_addr_o), .s1_aw_ready_i(s1_aw_ready_i),
    .s1_w_valid_o(s1_w_valid_o), .s1_w_data_o(s1_w_data_o), .s1_w_strb_o(s1_w_strb_o), .s1_w_ready_i(s1_w_ready_i),
    .s1_b_valid_i(s1_b_valid_i), .s1_b_resp_i(s1_b_resp_i), .s1_b_ready_o(s1_b_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_read(input logic [31:0] a);
    slv_ar_valid_i = 1; slv_ar_addr_i = a;
    tick();
    slv_ar_valid_i = 0; slv_ar_addr_i = 0;
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ar_ready", 32'(slv_ar_ready_o), 32'd1);
    chk("rst_aw_ready", 32'(slv_aw_ready_o), 32'd1);
    chk("rst_w_ready", 32'(slv_w_ready_o), 32'd1);
    chk("rst_valids", 32'({slv_r_valid_o, slv_b_valid_o, s0_ar_valid_o, s1_ar_valid_o,
                           s0_aw_valid_o, s1_aw_valid_o, s0_w_valid_o, s1_w_valid_o}), 32'd0);
    tick(); tick();
    rst_i = 1;
    tick();
    // read from SRAM, slave answers 3 cycles after address phase
    start_read(32'h8000_0010);
    chk("a_s0_ar_valid", 32'(s0_ar_valid_o), 32'd1);
    chk("a_s0_ar_addr", s0_ar_addr_o, 32'h8000_0010);
    chk("a_s1_ar_valid", 32'(s1_ar_valid_o), 32'd0);
    chk("a_ar_ready_busy", 32'(slv_ar_ready_o), 32'd0);
    s0_ar_ready_i = 1;
    tick();
    s0_ar_ready_i = 0; #1;
    chk("a_ar_valid_drop", 32'(s0_ar_valid_o), 32'd0);
    chk("a_r_valid_early", 32'(slv_r_valid_o), 32'd0);
    tick(); tick();
    s0_r_valid_i = 1; s0_r_data_i = 32'hDEAD_BEEF; s0_r_resp_i = RESP_OKAY; slv_r_ready_i = 1; #1;
    chk("a_r_valid", 32'(slv_r_valid_o), 32'd1);
    chk("a_r_data", slv_r_data_o, 32'hDEAD_BEEF);
    chk("a_r_resp", 32'(slv_r_resp_o), 32'd0);
    chk("a_s0_r_ready", 32'(s0_r_ready_o), 32'd1);
    tick();
    s0_r_valid_i = 0; s0_r_data_i = 0; slv_r_ready_i = 0; #1;
    chk("a_r_valid_done", 32'(slv_r_valid_o), 32'd0);
    chk("a_ar_ready_back", 32'(slv_ar_ready_o), 32'd1);
    // write to UART with W two cycles ahead of AW
    slv_w_valid_i = 1; slv_w_data_i = 32'h41; slv_w_strb_i = 4'b0001;
    tick();
    slv_w_valid_i = 0; slv_w_data_i = 0; slv_w_strb_i = 0; #1;
    chk("b_w_ready_held", 32'(slv_w_ready_o), 32'd0);
    chk("b_aw_ready", 32'(slv_aw_ready_o), 32'd1);
    chk("b_s1_w_early", 32'(s1_w_valid_o), 32'd0);
    tick();
    slv_aw_valid_i = 1; slv_aw_addr_i = 32'hA000_03F8;
    tick();
    slv_aw_valid_i = 0; slv_aw_addr_i = 0; #1;
    chk("b_s1_aw_valid", 32'(s1_aw_valid_o), 32'd1);
    chk("b_s1_aw_addr", s1_aw_addr_o, 32'hA000_03F8);
    chk("b_s1_w_valid", 32'(s1_w_valid_o), 32'd1);
    chk("b_s1_w_data", s1_w_data_o, 32'h41);
    chk("b_s1_w_strb", 32'(s1_w_strb_o), 32'd1);
    chk("b_s0_aw_valid", 32'(s0_aw_valid_o), 32'd0);
    s1_w_ready_i = 1;
    tick();
    s1_w_ready_i = 0; #1;
    chk("b_s1_w_drop", 32'(s1_w_valid_o), 32'd0);
    chk("b_s1_aw_hold", 32'(s1_aw_valid_o), 32'd1);
    s1_aw_ready_i = 1;
    tick();
    s1_aw_ready_i = 0; #1;
    chk("b_s1_aw_drop", 32'(s1_aw_valid_o), 32'd0);
    s1_b_valid_i = 1; s1_b_resp_i = RESP_OKAY; slv_b_ready_i = 1; #1;
    chk("b_b_valid", 32'(slv_b_valid_o), 32'd1);
    chk("b_b_resp", 32'(slv_b_resp_o), 32'd0);
    chk("b_s1_b_ready", 32'(s1_b_ready_o), 32'd1);
    tick();
    s1_b_valid_i = 0; slv_b_ready_i = 0; #1;
    chk("b_aw_ready_back", 32'(slv_aw_ready_o), 32'd1);
    // unmapped read
    start_read(32'h1000_0000);
`ifdef XBAR_DECERR_EN
    chk("c_r_valid", 32'(slv_r_valid_o), 32'd1);
    chk("c_r_data", slv_r_data_o, 32'd0);
    chk("c_r_resp", 32'(slv_r_resp_o), 32'd3);
    chk("c_no_s0", 32'(s0_ar_valid_o), 32'd0);
    slv_r_ready_i = 1;
    tick();
    slv_r_ready_i = 0; #1;
`else
    chk("c_s0_ar_valid", 32'(s0_ar_valid_o), 32'd1);
    chk("c_s0_ar_addr", s0_ar_addr_o, 32'h1000_0000);
    chk("c_r_valid_none", 32'(slv_r_valid_o), 32'd0);
    s0_ar_ready_i = 1;
    tick();
    s0_ar_ready_i = 0; s0_r_valid_i = 1; s0_r_data_i = 32'h0BAD_0001; slv_r_ready_i = 1; #1;
    chk("c_r_data", slv_r_data_o, 32'h0BAD_0001);
    tick();
    s0_r_valid_i = 0; s0_r_data_i = 0; slv_r_ready_i = 0; #1;
`endif
    chk("c_r_done", 32'(slv_r_valid_o), 32'd0);
    chk("c_ar_ready", 32'(slv_ar_ready_o), 32'd1);
    // concurrent read to UART and write to SRAM
    slv_ar_valid_i = 1; slv_ar_addr_i = 32'hA000_0004;
    slv_aw_valid_i = 1; slv_aw_addr_i = 32'h8000_0100;
    slv_w_valid_i = 1; slv_w_data_i = 32'h1234_5678; slv_w_strb_i = 4'hF;
    tick();
    slv_ar_valid_i = 0; slv_aw_valid_i = 0; slv_w_valid_i = 0; #1;
    chk("d_s1_ar_valid", 32'(s1_ar_valid_o), 32'd1);
    chk("d_s0_ar_valid", 32'(s0_ar_valid_o), 32'd0);
    chk("d_s0_aw_valid", 32'(s0_aw_valid_o), 32'd1);
    chk("d_s1_aw_valid", 32'(s1_aw_valid_o), 32'd0);
    chk("d_s0_w_data", s0_w_data_o, 32'h1234_5678);
    chk("d_s0_w_strb", 32'(s0_w_strb_o), 32'hF);
    s1_ar_ready_i = 1; s0_aw_ready_i = 1; s0_w_ready_i = 1;
    tick();
    s1_ar_ready_i = 0; s0_aw_ready_i = 0; s0_w_ready_i = 0;
    s1_r_valid_i = 1; s1_r_data_i = 32'hCAFE_F00D; s1_r_resp_i = RESP_OKAY; slv_r_ready_i = 1;
    s0_b_valid_i = 1; s0_b_resp_i = 2'b10; #1;
    chk("d_r_data", slv_r_data_o, 32'hCAFE_F00D);
    chk("d_b_valid", 32'(slv_b_valid_o), 32'd1);
    chk("d_b_resp", 32'(slv_b_resp_o), 32'd2);
    chk("d_b_ready_low", 32'({s0_b_ready_o, s1_b_ready_o}), 32'd0);
    tick();
    s1_r_valid_i = 0; slv_r_ready_i = 0; slv_b_ready_i = 1; #1;
    chk("d_r_done", 32'(slv_r_valid_o), 32'd0);
    chk("d_s0_b_ready", 32'(s0_b_ready_o), 32'd1);
    tick();
    s0_b_valid_i = 0; slv_b_ready_i = 0; #1;
    chk("d_b_done", 32'(slv_b_valid_o), 32'd0);
    // upstream r backpressure while a new AR waits
    start_read(32'h8000_0020);
    s0_ar_ready_i = 1;
    tick();
    s0_ar_ready_i = 0; s0_r_valid_i = 1; s0_r_data_i = 32'h1357_9BDF;
    slv_ar_valid_i = 1; slv_ar_addr_i = 32'h8000_0030; #1;
    for (int i = 0; i < 5; i++) begin
      chk("e_r_valid", 32'(slv_r_valid_o), 32'd1);
      chk("e_r_data", slv_r_data_o, 32'h1357_9BDF);
      chk("e_ar_ready", 32'(slv_ar_ready_o), 32'd0);
      tick();
    end
    slv_ar_valid_i = 0; slv_r_ready_i = 1;
    tick();
    s0_r_valid_i = 0; s0_r_data_i = 0; slv_r_ready_i = 0; #1;
    chk("e_no_extra_ar", 32'(s0_ar_valid_o), 32'd0);
    chk("e_ar_ready", 32'(slv_ar_ready_o), 32'd1);
    // reset during the address phase
    start_read(32'h8000_0040);
    chk("f_s0_ar_valid", 32'(s0_ar_valid_o), 32'd1);
    rst_i = 0; #1;
    chk("f_async_drop", 32'(s0_ar_valid_o), 32'd0);
    tick();
    rst_i = 1; #1;
    chk("f_ar_ready", 32'(slv_ar_ready_o), 32'd1);
    chk("f_r_valid", 32'(slv_r_valid_o), 32'd0);
    tick();
    chk("f_still_idle", 32'(s0_ar_valid_o), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_xbar.md
# axi_lite_xbar

One-master-to-two-slave AXI-lite router between the core's arbitrated memory port and the downstream slaves (slave 0 = SRAM/default, slave 1 = UART/MMIO). It decodes each read and write address and forwards the transaction to the selected slave. It returns the response on the matching channel and answers unmapped addresses internally. Read and write paths are independent, and each path allows one outstanding transaction.

## Interface
Parameters:
- SLV1_BASE, 32'hA000_0000, base of slave-1 window
- SLV1_MASK, 32'hFFFF_F000, slave-1 hit when (addr & SLV1_MASK) == SLV1_BASE
- SLV0_BASE, 32'h8000_0000, base of slave-0 window
- SLV0_MASK, 32'hF800_0000, slave-0 hit mask

Ports (groups share one prefix; directions and widths are listed in order):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- slv_ar_{valid_i,addr_i,ready_o}  in/in/out  1/32/1  upstream read address
- slv_r_{valid_o,data_o,resp_o,ready_i}  out/out/out/in  1/32/axi_resp_t/1  upstream read data
- slv_aw_{valid_i,addr_i,ready_o}  in/in/out  1/32/1  upstream write address
- slv_w_{valid_i,data_i,strb_i,ready_o}  in/in/in/out  1/32/4/1  upstream write data
- slv_b_{valid_o,resp_o,ready_i}  out/out/in  1/axi_resp_t/1  upstream write response
- s{0,1}_ar_{valid_o,addr_o,ready_i}  out/out/in  1/32/1  downstream read address, per slave
- s{0,1}_r_{valid_i,data_i,resp_i,ready_o}  in/in/in/out  1/32/axi_resp_t/1  downstream read data
- s{0,1}_aw_{valid_o,addr_o,ready_i}, s{0,1}_w_{valid_o,data_o,strb_o,ready_i}, s{0,1}_b_{valid_i,resp_i,ready_o}  downstream write channels, same widths as the upstream write channels

## Operation
- Decode priority: slave 1 hit first, then slave 0 hit, otherwise unmapped (ERR).
- Read FSM states R_IDLE, R_ADDR, R_DATA, R_ERR:
  - R_IDLE: slv_ar_ready_o=1. On AR handshake, latch addr and sel. Go to R_ERR if unmapped, else R_ADDR.
  - R_ADDR: selected s*_ar_valid_o=1 with the latched addr. On s*_ar_ready_i go to R_DATA.
  - R_DATA: slv_r_* is passed through from the selected slave; s*_r_ready_o = slv_r_ready_i. On r handshake go to R_IDLE.
  - R_ERR: slv_r_valid_o=1, data=0, resp=DECERR(2'b11). On slv_r_ready_i go to R_IDLE.
- Write FSM states W_IDLE, W_REQ, W_RESP, W_ERR:
  - W_IDLE: aw_ready and w_ready are independent. AW and W are each latched with their own "captured" flag, in either order or in the same cycle. Once both flags are set, decode and go to W_REQ or W_ERR.
  - W_REQ: s*_aw_valid_o and s*_w_valid_o are driven from the latches. Each drops on its own handshake. When both are done, go to W_RESP.
  - W_RESP: b is passed through from the selected slave. On b handshake go to W_IDLE.
  - W_ERR: slv_b_valid_o=1, resp=DECERR. On ready go to W_IDLE.
- Unselected slave outputs are held at 0. Upstream valids outside the response states are 0.

## Timing
- Reset: all FSMs go to IDLE, captured flags are cleared, latches are 0, and every valid output is 0. Ready outputs in IDLE are 1 (slv_ar_ready_o and slv_aw_ready_o are combinational on state).
- Request latency: downstream valid is asserted the cycle after upstream acceptance (1 added cycle). The response path is combinational (0 added cycles).
- DECERR response is valid 1 cycle after acceptance.
- A new AR is accepted no earlier than the cycle after the R handshake (same rule for AW/W vs B).
- Upstream AR held while not ready: the address must stay stable. It is latched only at the handshake.
- Reset asserted mid-transaction: the transaction is dropped with no response. The downstream valid drops asynchronously.

## Configuration
- XBAR_DECERR_EN defined: unmapped addresses go to R_ERR/W_ERR and return DECERR.
- XBAR_DECERR_EN undefined: unmapped addresses route to slave 0. The ERR states do not exist.

## Structure
- Shared package holds:
  - axi_resp_t
  - the OKAY/DECERR response constants
  - the read and write FSM state enums
- Sub-module xbar_addr_dec: combinational addr → {sel, err}. It is instanced twice, once for the read path and once for the write path.

## Test plan
- Read 0x8000_0010, s0 returns 32'hDEAD_BEEF with OKAY after 3 cycles → upstream r gets DEADBEEF/OKAY; s1 sees no ar_valid.
- Write 0xA000_03F8 data 0x41 strb 4'b0001, W presented 2 cycles before AW → s1 gets aw and w; B resp is OKAY.
- Read 0x1000_0000 with XBAR_DECERR_EN → r_valid 1 cycle after AR handshake, data 0, resp 2'b11. Without the macro → routed to s0.
- Simultaneous read to s1 and write to s0 → both complete independently, with no interleaving on outputs.
- slv_r_ready_i held low 5 cycles in R_DATA → r_valid and data stable, and no new AR is accepted.
- rst_i pulsed low during R_ADDR → s0_ar_valid_o drops immediately; after release, slv_ar_ready_o=1.
